// File: rtl/cla_subtractor_serial_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the nibble-serial CLA subtractor.
//   NIB_W   : width of one arithmetic slice (bits processed per cycle)
//   state_t : control FSM states of the serial subtractor
// ---------------------------------------------------------------------------
package cla_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_subtractor_serial_cla4_slice.sv
// ---------------------------------------------------------------------------
// cla4_slice
// Combinational 4-bit carry-look-ahead adder slice: {co, s} = x + y + ci.
//   x[3:0], y[3:0] : addend nibbles
//   ci             : carry in
//   s[3:0]         : sum nibble
//   co             : carry out (c4)
// ---------------------------------------------------------------------------
module cla4_slice
    import cla_pkg::*;
(
    input  logic [NIB_W-1:0] x,
    input  logic [NIB_W-1:0] y,
    input  logic             ci,
    output logic [NIB_W-1:0] s,
    output logic             co
);

    logic [NIB_W-1:0] w_g;
    logic [NIB_W-1:0] w_p;
    logic             w_c1;
    logic             w_c2;
    logic             w_c3;
    logic             w_c4;

    assign w_g = x & y;
    assign w_p = x ^ y;

    // Every carry is a flat sum of products of g/p terms, no ripple chain.
    assign w_c1 = w_g[0] | (w_p[0] & ci);
    assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
    assign w_c3 = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & ci);
    assign w_c4 = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

    assign s  = w_p ^ {w_c3, w_c2, w_c1, ci};
    assign co = w_c4;

endmodule

// File: rtl/cla_subtractor_serial.sv
// ---------------------------------------------------------------------------
// cla_subtractor_serial
// Multi-cycle WIDTH-bit subtractor, diff = a - b - bin (mod 2^WIDTH), one
// nibble per cycle LSB first through a single 4-bit CLA slice.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready high only in IDLE)
//   a, b, bin            : minuend, subtrahend, borrow in
//   out_valid / out_ready: result handshake (out_valid high only in DONE)
//   diff                 : difference
//   bout                 : borrow out, 1 iff unsigned a < b + bin
//   ovf                  : signed overflow of the subtraction
//   zero                 : diff == 0
// ---------------------------------------------------------------------------
module cla_subtractor_serial
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int NUM_NIB = WIDTH / NIB_W;
    localparam int CNT_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;

    generate
        if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_width_check
            $error("cla_subtractor_serial: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_ovf;
    logic               r_zero;

    logic               w_accept;
    logic               w_last;
    logic [NIB_W-1:0]   w_a_nib;
    logic [NIB_W-1:0]   w_b_nib;
    logic [NIB_W-1:0]   w_s;
    logic               w_co;
    logic [WIDTH-1:0]   w_diff_nxt;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_last   = (r_cnt == CNT_W'(NUM_NIB - 1));

    // Select the active operand nibbles and splice the slice result back
    // into the running difference at the same position.
    always_comb begin
        w_a_nib    = '0;
        w_b_nib    = '0;
        w_diff_nxt = r_diff;
        for (int i = 0; i < NUM_NIB; i++) begin
            if (r_cnt == CNT_W'(i)) begin
                w_a_nib = r_a[i*NIB_W +: NIB_W];
                w_b_nib = r_b[i*NIB_W +: NIB_W];
                w_diff_nxt[i*NIB_W +: NIB_W] = w_s;
            end
        end
    end

    // Subtraction as a + ~b + carry; the carry register holds ~borrow.
    cla4_slice u_slice (
        .x  (w_a_nib),
        .y  (~w_b_nib),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand registers carry no state worth resetting.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= a;
            r_b <= b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_carry <= ~bin;
        end else if (r_state == RUN) begin
            r_carry <= w_co;
            r_diff  <= w_diff_nxt;
            if (w_last) begin
                // Flags are taken from the completed difference so they
                // become valid on the same edge as out_valid.
                r_bout <= ~w_co;
                r_ovf  <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                          (w_diff_nxt[WIDTH-1] != r_a[WIDTH-1]);
                r_zero <= (w_diff_nxt == '0);
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_cla_subtractor_serial.sv
module tb_cla_subtractor_serial;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;

    always #5 clk = ~clk;

    cla_subtractor_serial #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        logic         zero;
    } vec_t;

    vec_t vecs[10];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called and returns at a falling edge; ends just after the accept edge.
    task automatic start_op(input logic [W-1:0] a_i, input logic [W-1:0] b_i, input logic bin_i);
        int t;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_before_start", {31'd0, in_ready}, 32'd1);
        a        = a_i;
        b        = b_i;
        bin      = bin_i;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, 32'd4);
    endtask

    task automatic check_result(input string tag, input vec_t v);
        chk({tag, "_diff"},     {16'd0, diff},      {16'd0, v.diff});
        chk({tag, "_bout"},     {31'd0, bout},      {31'd0, v.bout});
        chk({tag, "_ovf"},      {31'd0, ovf},       {31'd0, v.ovf});
        chk({tag, "_zero"},     {31'd0, zero},      {31'd0, v.zero});
        chk({tag, "_in_ready"}, {31'd0, in_ready},  32'd0);
    endtask

    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_idle_in_ready"},  {31'd0, in_ready},  32'd1);
        chk({tag, "_idle_out_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [W-1:0] held_diff;
        logic         saw_valid;
        vec_t         v;

        //             a         b         bin   diff      bout  ovf   zero
        vecs[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'h4B4B, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{16'h1000, 16'h0FFF, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_diff",      {16'd0, diff},      32'd0);
        chk("rst_bout",      {31'd0, bout},      32'd0);
        chk("rst_ovf",       {31'd0, ovf},       32'd0);
        chk("rst_zero",      {31'd0, zero},      32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].bin);
            wait_done($sformatf("vec%0d", i));
            check_result($sformatf("vec%0d", i), vecs[i]);
            finish_op($sformatf("vec%0d", i));
        end

        // Backpressure: result must hold and new operands must be refused.
        start_op(16'h0005, 16'h0003, 1'b0);
        wait_done("bp");
        held_diff = diff;
        chk("bp_diff_initial", {16'd0, held_diff}, 32'h0002);
        for (int c = 0; c < 5; c++) begin
            a        = 16'hDEAD;
            b        = 16'h0001;
            bin      = 1'b1;
            in_valid = (c % 2) == 0;
            @(negedge clk);
            chk($sformatf("bp%0d_out_valid", c), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp%0d_in_ready", c),  {31'd0, in_ready},  32'd0);
            chk($sformatf("bp%0d_diff", c),      {16'd0, diff},      32'h0002);
        end
        in_valid = 1'b0;
        finish_op("bp");

        // Reset during the second RUN cycle discards the partial result.
        start_op(16'h1234, 16'h0001, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_diff",      {16'd0, diff},      32'd0);
        chk("mrst_in_ready",  {31'd0, in_ready},  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        chk("mrst_no_out_valid", {31'd0, saw_valid}, 32'd0);

        v = '{16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0};
        start_op(v.a, v.b, v.bin);
        wait_done("post_rst");
        check_result("post_rst", v);
        finish_op("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cla_subtractor_serial.md
Name: cla_subtractor_serial

Overview:
- Multi-cycle WIDTH-bit subtractor with borrow-in and borrow-out. It is the inverse-direction companion of the team's 4-bit carry-look-ahead adder.
- Computes diff = a - b - bin one 4-bit nibble per cycle, LSB nibble first. Each nibble uses a 4-bit CLA slice; the inter-nibble carry is held in a register.
- Valid/ready handshake on both sides. Sits in datapaths that need wide subtraction at low area.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4; elaborate-time error otherwise.
- NUM_NIB, WIDTH/4, derived. Number of nibble cycles per operation. Not to be overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  minuend
- b  in  WIDTH  subtrahend
- bin  in  1  borrow in
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- diff  out  WIDTH  a - b - bin, modulo 2^WIDTH
- bout  out  1  borrow out; 1 iff unsigned a < b + bin
- ovf  out  1  signed overflow
- zero  out  1  diff == 0

Behaviour:
- Reset (async assert, sync deassert inside the block's usage):
  - state = IDLE; in_ready = 1
  - out_valid = 0; diff = 0; bout = 0; ovf = 0; zero = 0
  - nibble counter = 0; carry register = 0
- States IDLE, RUN, DONE.
  - in_ready = (state == IDLE).
  - out_valid = (state == DONE).
- IDLE:
  - On in_valid && in_ready, capture a, b into operand registers.
  - Set carry register = ~bin, nibble counter = 0, go to RUN.
  - in_valid without in_ready is ignored; the source must hold its operands.
- RUN, each cycle at nibble k:
  - Slice computes a[k] + ~b[k] + carry.
  - The 4-bit result is written to diff[4k+3:4k]; carry register takes the slice carry-out.
  - When k == NUM_NIB-1, go to DONE; otherwise k increments.
  - in_valid is ignored throughout RUN.
- DONE:
  - bout = ~carry register.
  - ovf = (a_msb != b_msb) && (diff_msb != a_msb).
  - zero = (diff == 0).
  - ovf and zero are registered on the final RUN edge so that they are valid together with out_valid.
  - On out_valid && out_ready, go to IDLE.
  - diff, bout, ovf and zero stay stable until the next operation's first RUN edge.
- Latency: operands accepted at edge E0; out_valid is high starting after edge E_NUM_NIB, i.e. NUM_NIB cycles after acceptance.
- Throughput: one result per NUM_NIB+2 cycles at best. There is no same-cycle accept in DONE: in_ready is 0 there, which gives one bubble through IDLE.
- Backpressure: with out_ready = 0 the block stays in DONE indefinitely, with outputs held and in_ready = 0.
- Counter width: max(1, clog2(NUM_NIB)). For WIDTH = 4 the block goes IDLE -> RUN (1 cycle) -> DONE.
- Reset mid-operation (RUN or DONE): returns to the reset values immediately. The partial result is discarded and no out_valid pulse is produced.
- Arithmetic is purely unsigned modulo 2^WIDTH; ovf is the only signed interpretation.

Decomposition:
- Shared package (cla_pkg):
  - NIB_W = 4
  - state typedef {IDLE, RUN, DONE}
- Sub-module cla4_slice, combinational:
  - Inputs x[3:0], y[3:0], ci.
  - Outputs s[3:0], co.
  - Generate/propagate look-ahead carries c1..c4.
  - The top level instantiates it once with y = ~b nibble; it is muxed by the nibble counter.

Test Plan (WIDTH=16):
- a=0x0005, b=0x0003, bin=0 -> after 4 cycles out_valid=1: diff=0x0002, bout=0, ovf=0, zero=0.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0, zero=0. Verifies the borrow ripples through all 4 nibble cycles.
- a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1. Also a=0x7FFF, b=0xFFFF -> diff=0x8000, bout=1, ovf=1.
- a=0x1234, b=0x1234, bin=0 -> diff=0x0000, zero=1, bout=0. Same operands with bin=1 -> diff=0xFFFF, bout=1, zero=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid and pulse in_valid with new operands. Required: outputs unchanged, in_ready=0, new operands not captured. Then out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-operation: assert rst_n=0 during the 2nd RUN cycle. Required: out_valid=0, diff=0 and in_ready=1 immediately after assertion. After release, a new operation 0x00FF-0x000F completes with diff=0x00F0.
